// File: rtl/encoder_8to3_seq_if.sv
// Request/code handshake bundle for encoder_8to3_seq.
// master: the encoder (drives code/valid/status, takes req/ready).
// slave:  the request source plus code consumer.
interface encoder_8to3_seq_if #(
    parameter int unsigned CODE_W = 3
);
    localparam int unsigned N = 1 << CODE_W;

    logic [N-1:0]      req;
    logic [CODE_W-1:0] code;
    logic              valid;
    logic              ready;
    logic [N-1:0]      pending;
    logic              busy;

    modport master (
        input  req,
        input  ready,
        output code,
        output valid,
        output pending,
        output busy
    );

    modport slave (
        output req,
        output ready,
        input  code,
        input  valid,
        input  pending,
        input  busy
    );
endinterface

// File: rtl/encoder_8to3_seq.sv
// Sequential 8-to-3 request encoder: sticky pending register feeding a
// valid/ready code issuer. Bit i of req maps to code i.
// Optional macro ROUND_ROBIN_EN: rotating priority starting after the last
// accepted code; otherwise lowest index wins.
module encoder_8to3_seq #(
    parameter int unsigned CODE_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    encoder_8to3_seq_if.master    bus
);
    localparam int unsigned N = 1 << CODE_W;

    typedef enum logic {StIdle, StHold} state_e;

    state_e            state_q, state_d;
    logic [N-1:0]      pending_q, pending_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              acc;
    logic [N-1:0]      clr;
    logic [N-1:0]      rem;
    logic [CODE_W-1:0] sel;
    logic              found;

    assign acc = (state_q == StHold) && bus.ready;
    assign clr = acc ? (N'(1) << code_q) : '0;
    // In IDLE clr is zero, so rem equals pending there.
    assign rem = pending_q & ~clr;

`ifdef ROUND_ROBIN_EN
    logic [CODE_W-1:0] ptr_q;

    // Search rem starting one past the last accepted code, wrapping.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            logic [CODE_W-1:0] idx;
            idx = CODE_W'((int'(ptr_q) + 1 + int'(k)) % int'(N));
            if (!found && rem[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    // Pointer follows every accepted code; reset to N-1 so the first search starts at 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= CODE_W'(N - 1);
        end else if (acc) begin
            ptr_q <= code_q;
        end
    end
`else
    // Fixed priority: lowest set index of rem.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && rem[i]) begin
                sel   = CODE_W'(i);
                found = 1'b1;
            end
        end
    end
`endif

    // Next-state: pending merge and issue FSM.
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        // req wins over clr on the same bit so the event is re-issued later.
        pending_d = rem | bus.req;
        unique case (state_q)
            StIdle: begin
                if (pending_q != '0) begin
                    code_d  = sel;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (acc) begin
                    if (found) begin
                        code_d = sel;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pending_q <= '0;
            code_q    <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            code_q    <= code_d;
        end
    end

    // Outputs.
    always_comb begin
        bus.valid   = (state_q == StHold);
        bus.code    = code_q;
        bus.pending = pending_q;
        bus.busy    = (state_q == StHold) || (pending_q != '0);
    end
endmodule
